wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//   Debug trace capture placed directly downstream of the pipelined MIPS core.
//   Records every architecturally visible register write-back as a {PC, dest reg, data} entry.
//   Entries go into a circular buffer. A PC-match trigger freezes the buffer a programmable
//   number of entries after the match. The frozen trace is then drained oldest-first over a
//   valid/ready port.
// PARAMETERS
//   DEPTH     8   number of trace entries; power of two, >=2
//   POST_CNT  2   entries captured after the trigger entry; 0..DEPTH-1
//   CNT_W     $clog2(DEPTH)+1   width of count (derived, not overridable)
// PORTS
//   clk         in   1      system clock, all logic on rising edge
//   rst         in   1      synchronous reset, active-low (0 = reset)
//   arm         in   1      1-cycle pulse: clear buffer and start capture
//   trig_pc     in   32     PC of the write-back that fires the trigger
//   wb_valid    in   1      write-back event this cycle (RegWrite of WB stage)
//   wb_pc       in   32     PC of the instruction writing back
//   wb_regdest  in   5      destination register of the write-back
//   wb_data     in   32     write-back data
//   rd_ready    in   1      consumer accepts rd_* this cycle
//   rd_valid    out  1      rd_* holds the oldest unread entry
//   rd_pc       out  32     entry PC
//   rd_regdest  out  5      entry destination register
//   rd_data     out  32     entry data
//   state       out  2      0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count       out  CNT_W  valid entries held, saturates at DEPTH
//   wrapped     out  1      at least one entry was overwritten since arm
//   triggered   out  1      trigger matched since arm
// BEHAVIOUR
//   Reset (rst==0 at clk edge): state=IDLE; count, wrapped and triggered=0; wr_ptr and rd_ptr=0;
//     rd_valid=0; rd_pc, rd_regdest and rd_data=0. Reset has priority over everything,
//     including mid-capture and mid-drain.
//   Qualified event: wb_valid==1 and wb_regdest!=0. Writes to $zero are never recorded.
//   Capture latency: an entry is visible in count on the cycle after its event.
//   arm (any state): next cycle state=ARMED; pointers, count, wrapped and triggered are cleared.
//     An event in the same cycle as arm is dropped.
//   FSM transitions:
//     IDLE:  only leaves on arm; events are ignored.
//     ARMED: each event is written at wr_ptr and wr_ptr increments modulo DEPTH.
//       count<DEPTH: count increments.
//       count==DEPTH: the oldest entry is overwritten, rd_ptr advances, wrapped is set.
//       Event with wb_pc==trig_pc: the entry is written and triggered is set.
//         POST_CNT==0 -> DONE; else -> POST with post_left=POST_CNT.
//     POST: same write rules as ARMED, no trigger compare. Each event decrements post_left;
//       the event that takes post_left to 0 is captured and moves to DONE.
//     DONE: capture is frozen and events are ignored. rd_valid = (count!=0).
//       rd_* show the entry at rd_ptr combinationally from storage.
//       Pop on rd_valid&&rd_ready: rd_ptr increments modulo DEPTH and count decrements.
//       rd_* show the next entry the following cycle.
//       After count reaches 0, rd_valid=0 and state stays DONE until arm.
//   rd_valid=0 in every state except DONE; rd_* retain their last value when rd_valid=0.
//   rd_* are stable while rd_valid&&!rd_ready.
//   Pointer arithmetic is modulo DEPTH with no extra wrap bit; count alone distinguishes full from empty.
// TESTING (DEPTH=8, POST_CNT=2)
//   Reset held 2 cycles: state=0, count=0, rd_valid=0, wrapped=0, triggered=0, rd_pc=0.
//   arm, trig_pc=0x100, then events at PC 0x0,0x4,0x8 (regdest 8, data 1,2,3):
//     state=1, count=3, wrapped=0, rd_valid=0.
//   arm, trig_pc=0x24, 12 events at PC 0x00..0x2C (step 4, regdest 9):
//     triggered at 0x24, DONE after 0x2C, count=8, wrapped=1.
//     Drain with rd_ready=1 yields PC 0x10..0x2C in order, then rd_valid=0.
//   Events with wb_regdest=0 interleaved among 3 real events: count=3 and no $zero entries appear.
//   arm and wb_valid in the same cycle: that event is not recorded (count=0 the next cycle).
//   In DONE hold rd_ready=0 for 5 cycles: rd_* unchanged.
//   rst=0 while in POST: state=0, count=0 on the next cycle.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// Write-back event and trace drain signals between the MIPS core side and the trace buffer.
interface wb_trace_buffer_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_regdest;
  logic [31:0] wb_data;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [4:0]  rd_regdest;
  logic [31:0] rd_data;

  modport master (
    output wb_valid, wb_pc, wb_regdest, wb_data, rd_ready,
    input  rd_valid, rd_pc, rd_regdest, rd_data
  );

  modport slave (
    input  wb_valid, wb_pc, wb_regdest, wb_data, rd_ready,
    output rd_valid, rd_pc, rd_regdest, rd_data
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Circular write-back trace buffer: captures {PC, dest reg, data}, freezes a fixed number of
// entries after a PC-match trigger, then drains the frozen trace oldest-first.
module wb_trace_buffer #(
  parameter int DEPTH    = 8,
  parameter int POST_CNT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [31:0]              trig_pc,
  wb_trace_buffer_if.slave         bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrapped,
  output logic                     triggered
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   post_left;

  logic [31:0]        mem_pc   [DEPTH];
  logic [4:0]         mem_rd   [DEPTH];
  logic [31:0]        mem_data [DEPTH];

  logic [31:0]        hold_pc;
  logic [4:0]         hold_rd;
  logic [31:0]        hold_data;

  logic               qualified;
  logic               capture;
  logic               trig_hit;
  logic               full;
  logic               valid;
  logic               pop;

  // Writes to $zero are not architecturally visible, so they never count as events.
  assign qualified = bus.wb_valid && (bus.wb_regdest != 5'd0);
  assign capture   = qualified && !arm && ((state_q == ARMED) || (state_q == POST));
  assign trig_hit  = capture && (state_q == ARMED) && (bus.wb_pc == trig_pc);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = valid && bus.rd_ready && !arm;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        ARMED: begin
          if (trig_hit) begin
            state_d = (POST_CNT == 0) ? DONE : POST;
          end
        end
        POST: begin
          if (capture && (post_left == CNT_W'(1))) begin
            state_d = DONE;
          end
        end
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Drain port reads storage directly while valid; otherwise it replays the last shown entry.
  always_comb begin
    valid          = (state_q == DONE) && (count != '0);
    bus.rd_valid   = valid;
    bus.rd_pc      = hold_pc;
    bus.rd_regdest = hold_rd;
    bus.rd_data    = hold_data;
    if (valid) begin
      bus.rd_pc      = mem_pc[rd_ptr];
      bus.rd_regdest = mem_rd[rd_ptr];
      bus.rd_data    = mem_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_pc[wr_ptr]   <= bus.wb_pc;
      mem_rd[wr_ptr]   <= bus.wb_regdest;
      mem_data[wr_ptr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
      post_left <= '0;
      hold_pc   <= '0;
      hold_rd   <= '0;
      hold_data <= '0;
    end else begin
      if (valid) begin
        hold_pc   <= mem_pc[rd_ptr];
        hold_rd   <= mem_rd[rd_ptr];
        hold_data <= mem_data[rd_ptr];
      end
      if (arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        wrapped   <= 1'b0;
        triggered <= 1'b0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          // A full buffer keeps the newest DEPTH entries by dropping the oldest.
          if (full) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            wrapped <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        if (trig_hit) begin
          triggered <= 1'b1;
          post_left <= CNT_W'(POST_CNT);
        end else if (capture && (state_q == POST)) begin
          post_left <= post_left - CNT_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          count  <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based trace model.
module tb_wb_trace_buffer;

  localparam int DEPTH    = 8;
  localparam int POST_CNT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        arm;
    logic [31:0] trig;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ready;
    logic [1:0]  e_state;
    logic [3:0]  e_count;
    logic        e_wrapped;
    logic        e_trig;
    logic        e_valid;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [31:0] trig_pc;
  logic [1:0]  state;
  logic [3:0]  count;
  logic        wrapped;
  logic        triggered;

  int cmp_count;
  int err_count;

  wb_trace_buffer_if bus();

  wb_trace_buffer #(.DEPTH(DEPTH), .POST_CNT(POST_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig_pc   (trig_pc),
    .bus       (bus),
    .state     (state),
    .count     (count),
    .wrapped   (wrapped),
    .triggered (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the trace is a queue of at most DEPTH entries, oldest at the front.
  entry_t m_q[$];
  int     m_state;
  int     m_post_left;
  bit     m_wrapped;
  bit     m_trig;
  entry_t m_hold;

  task automatic modelStep();
    bit     mv;
    entry_t e;
    mv = (m_state == 3) && (m_q.size() != 0);
    if (mv) m_hold = m_q[0];
    if (!rst) begin
      m_state   = 0;
      m_q.delete();
      m_wrapped = 0;
      m_trig    = 0;
      m_hold    = '0;
    end else if (arm) begin
      m_state   = 1;
      m_q.delete();
      m_wrapped = 0;
      m_trig    = 0;
    end else if ((m_state == 1 || m_state == 2) && bus.wb_valid && bus.wb_regdest != 5'd0) begin
      e.pc   = bus.wb_pc;
      e.rd   = bus.wb_regdest;
      e.data = bus.wb_data;
      m_q.push_back(e);
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_wrapped = 1;
      end
      if (m_state == 1) begin
        if (bus.wb_pc == trig_pc) begin
          m_trig = 1;
          if (POST_CNT == 0) m_state = 3;
          else begin
            m_state     = 2;
            m_post_left = POST_CNT;
          end
        end
      end else begin
        m_post_left--;
        if (m_post_left == 0) m_state = 3;
      end
    end else if (mv && bus.rd_ready) begin
      void'(m_q.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic [31:0] t,
                               input logic v, input logic [31:0] pc, input logic [4:0] rd,
                               input logic [31:0] data, input logic ready);
    rst            = r;
    arm            = a;
    trig_pc        = t;
    bus.wb_valid   = v;
    bus.wb_pc      = pc;
    bus.wb_regdest = rd;
    bus.wb_data    = data;
    bus.rd_ready   = ready;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    bit     mv;
    entry_t exp_e;
    mv    = (m_state == 3) && (m_q.size() != 0);
    exp_e = mv ? m_q[0] : m_hold;
    checkOutput("rnd_state", 64'(state), 64'(m_state));
    checkOutput("rnd_count", 64'(count), 64'(m_q.size()));
    checkOutput("rnd_wrapped", 64'(wrapped), 64'(m_wrapped));
    checkOutput("rnd_triggered", 64'(triggered), 64'(m_trig));
    checkOutput("rnd_rd_valid", 64'(bus.rd_valid), 64'(mv));
    checkOutput("rnd_rd_pc", 64'(bus.rd_pc), 64'(exp_e.pc));
    checkOutput("rnd_rd_regdest", 64'(bus.rd_regdest), 64'(exp_e.rd));
    checkOutput("rnd_rd_data", 64'(bus.rd_data), 64'(exp_e.data));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] rtrig;
    cmp_count = 0;
    err_count = 0;
    m_state = 0; m_post_left = 0; m_wrapped = 0; m_trig = 0; m_hold = '0;

    // Reset, idle events ignored, arm drops its same-cycle event, $zero writes skipped.
    vecs[0] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  5'd0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  5'd0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,  5'd8, 32'h9, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h100, 1'b1, 32'h50, 5'd8, 32'h7, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h0,  5'd8, 32'h1, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h4,  5'd8, 32'h2, 1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h8,  5'd0, 32'h5, 1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h8,  5'd8, 32'h3, 1'b0, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'hC,  5'd0, 32'h6, 1'b1, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].arm, vecs[i].trig, vecs[i].v, vecs[i].pc,
                    vecs[i].rd, vecs[i].data, vecs[i].ready);
      checkOutput($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      checkOutput($sformatf("vec%0d_wrapped", i), 64'(wrapped), 64'(vecs[i].e_wrapped));
      checkOutput($sformatf("vec%0d_triggered", i), 64'(triggered), 64'(vecs[i].e_trig));
      checkOutput($sformatf("vec%0d_rd_valid", i), 64'(bus.rd_valid), 64'(vecs[i].e_valid));
      if (i < 2) checkOutput($sformatf("vec%0d_rd_pc", i), 64'(bus.rd_pc), 64'h0);
    end

    // Wrap-around capture with trigger at 0x24, then frozen trace and drain.
    applyStimulus(1, 1, 32'h24, 0, 32'h0, 5'd0, 32'h0, 0);
    checkOutput("wrap_arm_state", 64'(state), 64'd1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 32'h24, 1, 32'(4 * i), 5'd9, 32'(32'h100 + i), 0);
      if (i == 6) checkOutput("wrap_count7", 64'(count), 64'd7);
      if (i == 7) begin
        checkOutput("wrap_count8", 64'(count), 64'd8);
        checkOutput("wrap_not_yet", 64'(wrapped), 64'd0);
      end
      if (i == 8) begin
        checkOutput("wrap_set", 64'(wrapped), 64'd1);
        checkOutput("wrap_pre_trig", 64'(triggered), 64'd0);
      end
      if (i == 9) begin
        checkOutput("trig_set", 64'(triggered), 64'd1);
        checkOutput("trig_post_state", 64'(state), 64'd2);
      end
      if (i == 10) checkOutput("post_state", 64'(state), 64'd2);
    end
    checkOutput("done_state", 64'(state), 64'd3);
    checkOutput("done_count", 64'(count), 64'd8);
    checkOutput("done_wrapped", 64'(wrapped), 64'd1);

    applyStimulus(1, 0, 32'h24, 1, 32'h30, 5'd9, 32'hdead, 0);
    checkOutput("done_ignores_event", 64'(count), 64'd8);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 32'h24, 0, 32'h0, 5'd0, 32'h0, 0);
      checkOutput($sformatf("stall%0d_valid", k), 64'(bus.rd_valid), 64'd1);
      checkOutput($sformatf("stall%0d_pc", k), 64'(bus.rd_pc), 64'h10);
      checkOutput($sformatf("stall%0d_data", k), 64'(bus.rd_data), 64'h104);
    end

    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain%0d_valid", k), 64'(bus.rd_valid), 64'd1);
      checkOutput($sformatf("drain%0d_pc", k), 64'(bus.rd_pc), 64'(32'h10 + 4 * k));
      checkOutput($sformatf("drain%0d_regdest", k), 64'(bus.rd_regdest), 64'd9);
      checkOutput($sformatf("drain%0d_data", k), 64'(bus.rd_data), 64'(32'h104 + k));
      applyStimulus(1, 0, 32'h24, 0, 32'h0, 5'd0, 32'h0, 1);
    end
    checkOutput("drained_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("drained_count", 64'(count), 64'd0);
    checkOutput("drained_state", 64'(state), 64'd3);
    checkOutput("drained_hold_pc", 64'(bus.rd_pc), 64'h2C);

    // Reset asserted in the middle of the post-trigger window.
    applyStimulus(1, 1, 32'h8, 0, 32'h0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 32'h8, 1, 32'(4 * i), 5'd3, 32'(i), 0);
    end
    checkOutput("midpost_state", 64'(state), 64'd2);
    checkOutput("midpost_count", 64'(count), 64'd4);
    applyStimulus(0, 0, 32'h8, 1, 32'h10, 5'd3, 32'h9, 0);
    checkOutput("rst_post_state", 64'(state), 64'd0);
    checkOutput("rst_post_count", 64'(count), 64'd0);
    checkOutput("rst_post_trig", 64'(triggered), 64'd0);

    // Randomized traffic against the queue model.
    rtrig = 32'h20;
    for (int n = 0; n < 4000; n++) begin
      logic r, a;
      r = ($urandom_range(0, 199) != 0);
      a = ($urandom_range(0, 29) == 0);
      if (a) rtrig = 32'($urandom_range(0, 15) * 4);
      applyStimulus(r, a, rtrig, logic'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4),
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom(), ($urandom_range(0, 9) < 6));
      checkModel();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
